memory_port_arbiter: RTL and testbench

- Shares one single-port synchronous RAM between the instruction-fetch requester and the L-ALU data requester.
- Memory-maps the 16-bit inputLine/outputLine I/O port at one address.
- Sits between the CPU core (fetch unit plus the L-ALU memoryAddress/memoryIn/memoryOut path) and the RAM.
- Every access is multi-cycle, with a request/ready handshake and round-robin arbitration.

---
 rtl/memory_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_memory_port_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares one single-port synchronous RAM between the
// instruction-fetch requester and the L-ALU data requester. It also maps the
// inputLine/outputLine I/O port onto one data-side address. Each access takes
// a fixed three cycles: IDLE (issue) -> ACCESS (capture) -> DONE (ready pulse).
module memory_port_arbiter #(
    parameter int                 DATA_W  = 16,
    parameter int                 ADDR_W  = 16,
    parameter logic [ADDR_W-1:0]  IO_ADDR = ADDR_W'(16'hFFFF)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetchReq,
    input  logic [ADDR_W-1:0] fetchAddress,
    output logic              fetchReady,
    output logic [DATA_W-1:0] fetchData,
    input  logic              dataReq,
    input  logic              dataWrite,
    input  logic [ADDR_W-1:0] dataAddress,
    input  logic [DATA_W-1:0] dataWriteValue,
    output logic              dataReady,
    output logic [DATA_W-1:0] dataReadValue,
    output logic [ADDR_W-1:0] ramAddress,
    output logic              ramWriteEnable,
    output logic [DATA_W-1:0] ramWriteData,
    input  logic [DATA_W-1:0] ramReadData,
    input  logic [DATA_W-1:0] inputLine,
    output logic [DATA_W-1:0] outputLine,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } stateType;

    // lastGrant encoding: 0 = fetch side, 1 = data side
    localparam logic GRANT_FETCH = 1'b0;
    localparam logic GRANT_DATA  = 1'b1;

    stateType state;
    stateType nextState;

    logic lastGrant;
    logic grantData;
    logic grantFetch;
    logic dataIsIo;

    // Operation captured at the issue cycle, consumed in ACCESS
    logic opIsData_p1;
    logic opWrite_p1;
    logic opIo_p1;

    // Address decode for the memory-mapped I/O port (data side only)
    function automatic logic isIoAddr(input logic [ADDR_W-1:0] addr);
        return addr == IO_ADDR;
    endfunction

    assign dataIsIo     = isIoAddr(dataAddress);
    assign ramWriteData = dataWriteValue;
    assign busy         = (state != IDLE);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Grant selection, RAM issue and next-state logic
    always_comb begin
        nextState      = state;
        grantData      = 1'b0;
        grantFetch     = 1'b0;
        ramAddress     = '0;
        ramWriteEnable = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the side that did not win last time is granted
                if (dataReq && (!fetchReq || lastGrant == GRANT_FETCH)) begin
                    grantData = 1'b1;
                end else if (fetchReq) begin
                    grantFetch = 1'b1;
                end
                if (grantData) begin
                    ramAddress     = dataAddress;
                    // I/O writes never reach RAM; reset suppresses any strobe
                    ramWriteEnable = dataWrite && !dataIsIo && !reset;
                    nextState      = ACCESS;
                end else if (grantFetch) begin
                    ramAddress = fetchAddress;
                    nextState  = ACCESS;
                end
            end
            ACCESS:  nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Operation capture, result registers, ready pulses and the output port
    always_ff @(posedge clock) begin
        if (reset) begin
            lastGrant     <= GRANT_FETCH;
            opIsData_p1   <= 1'b0;
            opWrite_p1    <= 1'b0;
            opIo_p1       <= 1'b0;
            fetchReady    <= 1'b0;
            dataReady     <= 1'b0;
            fetchData     <= '0;
            dataReadValue <= '0;
            outputLine    <= '0;
        end else begin
            fetchReady <= 1'b0;
            dataReady  <= 1'b0;
            // Issue stage: record the granted operation
            if (grantData || grantFetch) begin
                lastGrant   <= grantData ? GRANT_DATA : GRANT_FETCH;
                opIsData_p1 <= grantData;
                opWrite_p1  <= grantData && dataWrite;
                opIo_p1     <= grantData && dataIsIo;
                if (grantData && dataWrite && dataIsIo) begin
                    outputLine <= dataWriteValue;
                end
            end
            // Access stage: RAM data is valid now; the ready pulse lands in DONE
            if (state == ACCESS) begin
                if (opIsData_p1) begin
                    dataReady <= 1'b1;
                    if (!opWrite_p1) begin
                        dataReadValue <= opIo_p1 ? inputLine : ramReadData;
                    end
                end else begin
                    fetchReady <= 1'b1;
                    fetchData  <= ramReadData;
                end
            end
        end
    end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed testbench for memory_port_arbiter with a behavioural synchronous RAM.
module tb_memory_port_arbiter;

    logic        clock;
    logic        reset;
    logic        fetchReq;
    logic [15:0] fetchAddress;
    logic        fetchReady;
    logic [15:0] fetchData;
    logic        dataReq;
    logic        dataWrite;
    logic [15:0] dataAddress;
    logic [15:0] dataWriteValue;
    logic        dataReady;
    logic [15:0] dataReadValue;
    logic [15:0] ramAddress;
    logic        ramWriteEnable;
    logic [15:0] ramWriteData;
    logic [15:0] ramReadData;
    logic [15:0] inputLine;
    logic [15:0] outputLine;
    logic        busy;

    logic        loadEn;
    logic [15:0] loadAddr;
    logic [15:0] loadVal;
    logic [15:0] mem [0:65535];

    int errors;
    int checks;

    memory_port_arbiter #(
        .DATA_W (16),
        .ADDR_W (16),
        .IO_ADDR(16'hFFFF)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .fetchReq      (fetchReq),
        .fetchAddress  (fetchAddress),
        .fetchReady    (fetchReady),
        .fetchData     (fetchData),
        .dataReq       (dataReq),
        .dataWrite     (dataWrite),
        .dataAddress   (dataAddress),
        .dataWriteValue(dataWriteValue),
        .dataReady     (dataReady),
        .dataReadValue (dataReadValue),
        .ramAddress    (ramAddress),
        .ramWriteEnable(ramWriteEnable),
        .ramWriteData  (ramWriteData),
        .ramReadData   (ramReadData),
        .inputLine     (inputLine),
        .outputLine    (outputLine),
        .busy          (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single-port synchronous RAM: read data valid one cycle after address
    always @(posedge clock) begin
        if (loadEn) begin
            mem[loadAddr] <= loadVal;
        end else if (ramWriteEnable) begin
            mem[ramAddress] <= ramWriteData;
        end
        ramReadData <= mem[ramAddress];
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic check16(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b1;
        fetchReq = 1'b0;
        fetchAddress = 16'h0000;
        dataReq = 1'b0;
        dataWrite = 1'b0;
        dataAddress = 16'h0000;
        dataWriteValue = 16'h0000;
        inputLine = 16'h0000;
        loadEn = 1'b0;
        loadAddr = 16'h0000;
        loadVal = 16'h0000;

        // Preload RAM while reset is held
        tick();
        loadEn = 1'b1; loadAddr = 16'h0010; loadVal = 16'h1234;
        tick();
        loadAddr = 16'hFFFF; loadVal = 16'h7777;
        tick();
        loadEn = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        // Reset state
        check1 ("rst_fetchReady", fetchReady, 1'b0);
        check1 ("rst_dataReady", dataReady, 1'b0);
        check16("rst_fetchData", fetchData, 16'h0000);
        check16("rst_dataReadValue", dataReadValue, 16'h0000);
        check16("rst_outputLine", outputLine, 16'h0000);
        check1 ("rst_busy", busy, 1'b0);

        // Fetch read of 0x0010
        fetchReq = 1'b1; fetchAddress = 16'h0010;
        #1;
        check16("fetch_ramAddress", ramAddress, 16'h0010);
        check1 ("fetch_noWrite", ramWriteEnable, 1'b0);
        tick();
        check1 ("fetch_busyN1", busy, 1'b1);
        check1 ("fetch_readyN1", fetchReady, 1'b0);
        tick();
        check1 ("fetch_readyN2", fetchReady, 1'b1);
        check1 ("fetch_dataReadyN2", dataReady, 1'b0);
        check16("fetch_data", fetchData, 16'h1234);
        fetchReq = 1'b0;
        tick();
        check1 ("fetch_readyN3", fetchReady, 1'b0);
        check1 ("fetch_idle", busy, 1'b0);

        // Data write 0xBEEF to 0x0200
        dataReq = 1'b1; dataWrite = 1'b1; dataAddress = 16'h0200; dataWriteValue = 16'hBEEF;
        #1;
        check1 ("wr_weN", ramWriteEnable, 1'b1);
        check16("wr_ramAddress", ramAddress, 16'h0200);
        check16("wr_ramWriteData", ramWriteData, 16'hBEEF);
        tick();
        check1 ("wr_weN1", ramWriteEnable, 1'b0);
        tick();
        check1 ("wr_readyN2", dataReady, 1'b1);
        check1 ("wr_fetchReadyN2", fetchReady, 1'b0);
        check16("wr_readValueKept", dataReadValue, 16'h0000);
        dataReq = 1'b0;
        tick();

        // Data read back from 0x0200
        dataReq = 1'b1; dataWrite = 1'b0; dataAddress = 16'h0200;
        #1;
        check1 ("rd_noWrite", ramWriteEnable, 1'b0);
        tick();
        tick();
        check1 ("rd_readyN2", dataReady, 1'b1);
        check16("rd_value", dataReadValue, 16'hBEEF);
        dataReq = 1'b0;
        tick();
        check1 ("rd_readyN3", dataReady, 1'b0);

        // I/O write 0x00A5 to 0xFFFF
        dataReq = 1'b1; dataWrite = 1'b1; dataAddress = 16'hFFFF; dataWriteValue = 16'h00A5;
        #1;
        check1 ("iow_noRamWrite", ramWriteEnable, 1'b0);
        tick();
        check16("iow_outputLine", outputLine, 16'h00A5);
        check1 ("iow_noRamWriteN1", ramWriteEnable, 1'b0);
        tick();
        check1 ("iow_readyN2", dataReady, 1'b1);
        dataReq = 1'b0;
        tick();

        // I/O read: inputLine sampled in the ACCESS cycle
        dataReq = 1'b1; dataWrite = 1'b0; dataAddress = 16'hFFFF; inputLine = 16'h1111;
        tick();
        inputLine = 16'h5A5A;
        tick();
        check1 ("ior_readyN2", dataReady, 1'b1);
        check16("ior_value", dataReadValue, 16'h5A5A);
        check16("ior_outputHeld", outputLine, 16'h00A5);
        dataReq = 1'b0;
        tick();

        // Fetch of 0xFFFF is an ordinary RAM read, and RAM[0xFFFF] was untouched
        fetchReq = 1'b1; fetchAddress = 16'hFFFF;
        #1;
        check16("fetchIo_ramAddress", ramAddress, 16'hFFFF);
        tick();
        tick();
        check1 ("fetchIo_ready", fetchReady, 1'b1);
        check16("fetchIo_data", fetchData, 16'h7777);
        check1 ("fetchIo_noDataReady", dataReady, 1'b0);
        fetchReq = 1'b0;
        tick();

        // Requests changing during ACCESS are ignored
        dataReq = 1'b1; dataWrite = 1'b0; dataAddress = 16'h0010;
        tick();
        dataAddress = 16'h0200; dataWrite = 1'b1; dataWriteValue = 16'hDEAD;
        #1;
        check1 ("ign_busyN1", busy, 1'b1);
        check1 ("ign_noWriteN1", ramWriteEnable, 1'b0);
        tick();
        check1 ("ign_busyN2", busy, 1'b1);
        check1 ("ign_readyN2", dataReady, 1'b1);
        check16("ign_value", dataReadValue, 16'h1234);
        dataReq = 1'b0; dataWrite = 1'b0;
        tick();
        check1 ("ign_idleN3", busy, 1'b0);

        // Reset in ACCESS of a data write: no ready, no write strobe under reset
        dataReq = 1'b1; dataWrite = 1'b1; dataAddress = 16'h0300; dataWriteValue = 16'h1111;
        tick();
        reset = 1'b1;
        tick();
        check1 ("rstm_noWe", ramWriteEnable, 1'b0);
        check1 ("rstm_noReady", dataReady, 1'b0);
        check1 ("rstm_idle", busy, 1'b0);
        reset = 1'b0; dataReq = 1'b0; dataWrite = 1'b0;
        tick();
        check1 ("rstm_noReadyAfter", dataReady, 1'b0);
        check1 ("rstm_busy", busy, 1'b0);
        check16("rstm_outputLine", outputLine, 16'h0000);
        check16("rstm_dataReadValue", dataReadValue, 16'h0000);

        // Arbitration: both held high after reset -> data, fetch, data, ...
        fetchReq = 1'b1; fetchAddress = 16'h0010;
        dataReq = 1'b1; dataWrite = 1'b0; dataAddress = 16'h0200;
        #1;
        check16("arb_grant0", ramAddress, 16'h0200);
        for (int k = 1; k <= 12; k++) begin
            tick();
            check1($sformatf("arb_dataReady%0d", k), dataReady, (k % 6) == 2);
            check1($sformatf("arb_fetchReady%0d", k), fetchReady, (k % 6) == 5);
            if ((k % 3) == 0) begin
                check16($sformatf("arb_grant%0d", k), ramAddress,
                        ((k % 6) == 0) ? 16'h0200 : 16'h0010);
            end
        end
        fetchReq = 1'b0; dataReq = 1'b0;
        check16("arb_dataValue", dataReadValue, 16'hBEEF);
        check16("arb_fetchValue", fetchData, 16'h1234);
        tick();
        tick();
        check1("arb_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
